// File: rtl/busq_instr.sv
// Instruction fetch: holds the PC, reads instruction memory over req/ack, presents the word and its opcode.
// Latency: word valid the cycle after mem_ack is sampled; next request one edge later (2 cycles/instr minimum).
// Backpressure: detener freezes the presented instruction, PC and outputs; memory stalls simply hold mem_req.
// Optional feature: define BUSQ_TIMEOUT_EN to abandon a request after LIMITE_ESPERA cycles and raise error_bus.
module busq_instr #(
    parameter int                   ANCHO_DIR     = 32,
    parameter logic [ANCHO_DIR-1:0] PC_INICIO     = '0,
    parameter int                   LIMITE_ESPERA = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 mem_req,
    output logic [ANCHO_DIR-1:0] mem_dir,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_dato,
    input  logic                 detener,
    input  logic                 salto_tomado,
    input  logic [ANCHO_DIR-1:0] dir_salto,
    output logic                 instr_valida,
    output logic [31:0]          instr_completa,
    output logic [5:0]           instru,
    output logic [ANCHO_DIR-1:0] pc_actual,
    output logic                 error_bus
);

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        PEDIR    = 2'd1,
        ENTREGAR = 2'd2
    } estado_t;

    estado_t              estado;
    logic [ANCHO_DIR-1:0] pc;
    logic [ANCHO_DIR-1:0] pc_siguiente;

    // The fetch address is the PC register itself, so it is word aligned and stable while waiting.
    assign mem_dir = pc;

    // Sequential next PC: taken branch target with the byte offset cleared, otherwise +4 (wraps naturally).
    always_comb begin
        pc_siguiente = pc + ANCHO_DIR'(4);
        if (salto_tomado) begin
            pc_siguiente = {dir_salto[ANCHO_DIR-1:2], 2'b00};
        end
    end

`ifdef BUSQ_TIMEOUT_EN
    localparam int ANCHO_ESPERA = (LIMITE_ESPERA > 1) ? $clog2(LIMITE_ESPERA) : 1;

    logic [ANCHO_ESPERA-1:0] espera;
    logic                    error_q;
    logic                    unused_bits;

    assign error_bus   = error_q;
    assign unused_bits = ^dir_salto[1:0];
`else
    logic unused_bits;

    assign error_bus   = 1'b0;
    assign unused_bits = ^{dir_salto[1:0], LIMITE_ESPERA[0]};
`endif

    // Fetch FSM: idle one cycle, request until ack, present until downstream releases, then step the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= INACTIVO;
            pc             <= PC_INICIO;
            mem_req        <= 1'b0;
            instr_valida   <= 1'b0;
            instr_completa <= '0;
            instru         <= '0;
            pc_actual      <= PC_INICIO;
`ifdef BUSQ_TIMEOUT_EN
            espera         <= '0;
            error_q        <= 1'b0;
`endif
        end else begin
            case (estado)
                INACTIVO: begin
                    // Any ack seen here belongs to an abandoned request and is dropped.
                    mem_req      <= 1'b1;
                    instr_valida <= 1'b0;
                    estado       <= PEDIR;
`ifdef BUSQ_TIMEOUT_EN
                    espera       <= '0;
`endif
                end
                PEDIR: begin
                    if (mem_ack) begin
                        instr_completa <= mem_dato;
                        instru         <= mem_dato[31:26];
                        pc_actual      <= pc;
                        instr_valida   <= 1'b1;
                        mem_req        <= 1'b0;
                        estado         <= ENTREGAR;
                    end
`ifdef BUSQ_TIMEOUT_EN
                    else if (espera == ANCHO_ESPERA'(LIMITE_ESPERA - 1)) begin
                        // Give up on this request; the same PC is re-requested after one idle cycle.
                        error_q <= 1'b1;
                        mem_req <= 1'b0;
                        estado  <= INACTIVO;
                    end else begin
                        espera <= espera + 1'b1;
                    end
`endif
                end
                ENTREGAR: begin
                    // Branch and step only take effect once the stall is released.
                    if (!detener) begin
                        pc           <= pc_siguiente;
                        instr_valida <= 1'b0;
                        mem_req      <= 1'b1;
                        estado       <= PEDIR;
`ifdef BUSQ_TIMEOUT_EN
                        espera       <= '0;
`endif
                    end
                end
                default: begin
                    mem_req      <= 1'b0;
                    instr_valida <= 1'b0;
                    estado       <= INACTIVO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_busq_instr.sv
// Bench for busq_instr: directed fetch scenarios, a per-cycle reference model of the fetch unit's
// observable behaviour, and literal checks on the hand-computed key values of each scenario.
module tb_busq_instr;

    localparam int          AW  = 32;
    localparam logic [31:0] PC0 = 32'h0000_0000;
    localparam int          LIM = 16;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_dir;
    logic        mem_ack;
    logic [31:0] mem_dato;
    logic        detener;
    logic        salto_tomado;
    logic [31:0] dir_salto;
    logic        instr_valida;
    logic [31:0] instr_completa;
    logic [5:0]  instru;
    logic [31:0] pc_actual;
    logic        error_bus;

    busq_instr #(
        .ANCHO_DIR    (AW),
        .PC_INICIO    (PC0),
        .LIMITE_ESPERA(LIM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req       (mem_req),
        .mem_dir       (mem_dir),
        .mem_ack       (mem_ack),
        .mem_dato      (mem_dato),
        .detener       (detener),
        .salto_tomado  (salto_tomado),
        .dir_salto     (dir_salto),
        .instr_valida  (instr_valida),
        .instr_completa(instr_completa),
        .instru        (instru),
        .pc_actual     (pc_actual),
        .error_bus     (error_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // ---------------- instruction memory model ----------------
    logic [31:0] imem [logic [31:0]];
    int          lat       = 1;
    int          wcnt      = 0;
    logic        mem_block = 1'b0;
    logic        late_ack  = 1'b0;

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        if (imem.exists(a)) return imem[a];
        return {6'h3F, a[25:0]};
    endfunction

    // One clock: at the falling edge, drive the memory response for the request currently visible.
    task automatic cyc();
        @(negedge clk);
        if (late_ack) begin
            mem_ack  = 1'b1;
            mem_dato = 32'hDEAD_BEEF;
        end else if (mem_req && !mem_block) begin
            if (wcnt >= lat) begin
                mem_ack  = 1'b1;
                mem_dato = fetch_word(mem_dir);
                wcnt     = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!instr_valida && k < 30);
        nchk++;
        if (!instr_valida) begin
            nerr++;
            $display("FAIL wait_valid at %0t: instr_valida got 0 after %0d cycles, want 1", $time, k);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    // The unit is in one of three observable situations: idle (neither requesting nor presenting),
    // requesting (mem_req high) or presenting (instr_valida high). The model follows those.
    logic        e_req, e_val, e_err;
    logic [31:0] e_dir, e_ir, e_pc;
    int          tcnt;

    initial begin
        e_req = 1'b0; e_val = 1'b0; e_err = 1'b0;
        e_dir = PC0;  e_ir  = '0;   e_pc  = PC0;
        tcnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                e_req = 1'b0; e_val = 1'b0; e_err = 1'b0;
                e_dir = PC0;  e_ir  = '0;   e_pc  = PC0;
                tcnt  = 0;
            end else if (e_val) begin
                if (!detener) begin
                    e_val = 1'b0;
                    e_req = 1'b1;
                    tcnt  = 0;
                    e_dir = salto_tomado ? (dir_salto & 32'hFFFF_FFFC) : (e_dir + 32'd4);
                end
            end else if (e_req) begin
                if (mem_ack) begin
                    e_req = 1'b0;
                    e_val = 1'b1;
                    e_ir  = mem_dato;
                    e_pc  = e_dir;
                end
`ifdef BUSQ_TIMEOUT_EN
                else if (tcnt == LIM - 1) begin
                    e_req = 1'b0;
                    e_err = 1'b1;
                end else begin
                    tcnt++;
                end
`endif
            end else begin
                e_req = 1'b1;
                tcnt  = 0;
            end
            chk("mem_req",        {31'b0, mem_req},      {31'b0, e_req});
            chk("mem_dir",        mem_dir,               e_dir);
            chk("mem_dir_align",  {30'b0, mem_dir[1:0]}, 32'h0);
            chk("instr_valida",   {31'b0, instr_valida}, {31'b0, e_val});
            chk("instr_completa", instr_completa,        e_ir);
            chk("instru",         {26'b0, instru},       {26'b0, e_ir[31:26]});
            chk("pc_actual",      pc_actual,             e_pc);
            chk("error_bus",      {31'b0, error_bus},    {31'b0, e_err});
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        rst_n        = 1'b0;
        mem_ack      = 1'b0;
        mem_dato     = '0;
        detener      = 1'b0;
        salto_tomado = 1'b0;
        dir_salto    = '0;
        imem[32'h0]  = 32'h8C08_0004;

        // Reset state and first fetch with a one-cycle memory.
        cyc();
        cyc();
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_dir", mem_dir, 32'h0);
        chk("rst_valid",   {31'b0, instr_valida}, 32'h0);
        chk("rst_instru",  {26'b0, instru}, 32'h0);
        chk("rst_error",   {31'b0, error_bus}, 32'h0);
        rst_n = 1'b1;
        wait_valid();
        chk("t1_instru", {26'b0, instru}, 32'h0000_0023);
        chk("t1_ir",     instr_completa, 32'h8C08_0004);
        chk("t1_pc",     pc_actual, 32'h0);
        cyc();
        chk("t1_valid_drop", {31'b0, instr_valida}, 32'h0);
        chk("t1_next_req",   {31'b0, mem_req}, 32'h1);
        chk("t1_next_dir",   mem_dir, 32'h4);

        // Reset while a request is outstanding; a late ack arrives two cycles later.
        cyc();
        chk("t5_req_before", {31'b0, mem_req}, 32'h1);
        rst_n   = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("t5_rst_req",   {31'b0, mem_req}, 32'h0);
        chk("t5_rst_dir",   mem_dir, 32'h0);
        chk("t5_rst_valid", {31'b0, instr_valida}, 32'h0);
        chk("t5_rst_ir",    instr_completa, 32'h0);
        chk("t5_rst_pc",    pc_actual, 32'h0);
        imem.delete();
        imem[32'h0] = 32'h0000_0020;
        imem[32'h4] = 32'hAC08_0004;
        imem[32'h8] = 32'h1109_0003;
        cyc();
        late_ack = 1'b1;
        cyc();
        late_ack = 1'b0;
        rst_n    = 1'b1;
        cyc();
        chk("t5_refetch_req", {31'b0, mem_req}, 32'h1);
        chk("t5_refetch_dir", mem_dir, 32'h0);
        chk("t5_late_valid",  {31'b0, instr_valida}, 32'h0);
        chk("t5_late_ir",     instr_completa, 32'h0);

        // Sequential fetch, then zero-wait memory.
        wait_valid();
        chk("t2_instru0", {26'b0, instru}, 32'h0000_0000);
        chk("t2_pc0",     pc_actual, 32'h0);
        lat = 0;
        wait_valid();
        chk("t2_instru1", {26'b0, instru}, 32'h0000_002B);
        chk("t2_pc1",     pc_actual, 32'h4);
        wait_valid();
        chk("t2_instru2", {26'b0, instru}, 32'h0000_0004);
        chk("t2_pc2",     pc_actual, 32'h8);

        // Stall for three cycles; a branch offered during the stall must be ignored.
        detener      = 1'b1;
        salto_tomado = 1'b1;
        dir_salto    = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t3_hold_valid",  {31'b0, instr_valida}, 32'h1);
            chk("t3_hold_instru", {26'b0, instru}, 32'h0000_0004);
            chk("t3_hold_req",    {31'b0, mem_req}, 32'h0);
            chk("t3_hold_pc",     pc_actual, 32'h8);
            chk("t3_hold_dir",    mem_dir, 32'h8);
            if (i == 1) salto_tomado = 1'b0;
        end

        // Taken branch with a misaligned target.
        detener      = 1'b0;
        salto_tomado = 1'b1;
        dir_salto    = 32'h0000_0043;
        cyc();
        salto_tomado = 1'b0;
        chk("t4_valid_drop", {31'b0, instr_valida}, 32'h0);
        chk("t4_br_req",     {31'b0, mem_req}, 32'h1);
        chk("t4_br_dir",     mem_dir, 32'h0000_0040);
        wait_valid();
        chk("t4_br_instru", {26'b0, instru}, 32'h0000_003F);
        chk("t4_br_pc",     pc_actual, 32'h0000_0040);

        // Branch to the top word; the following sequential step wraps to zero.
        salto_tomado = 1'b1;
        dir_salto    = 32'hFFFF_FFFF;
        cyc();
        salto_tomado = 1'b0;
        chk("t4_top_dir", mem_dir, 32'hFFFF_FFFC);
        wait_valid();
        chk("t4_top_pc", pc_actual, 32'hFFFF_FFFC);
        mem_block = 1'b1;
        cyc();
        chk("t4_wrap_req", {31'b0, mem_req}, 32'h1);
        chk("t4_wrap_dir", mem_dir, 32'h0);

        // Memory never answers.
        n = 1;
        while (mem_req && n < 40) begin
            cyc();
            if (mem_req) n++;
        end
`ifdef BUSQ_TIMEOUT_EN
        chk("t6_req_cycles", n, LIM);
        chk("t6_err_set",    {31'b0, error_bus}, 32'h1);
        chk("t6_req_low",    {31'b0, mem_req}, 32'h0);
        mem_block = 1'b0;
        cyc();
        chk("t6_reissue_req", {31'b0, mem_req}, 32'h1);
        chk("t6_reissue_dir", mem_dir, 32'h0);
`else
        chk("t6_req_cycles", n, 40);
        chk("t6_err_zero",   {31'b0, error_bus}, 32'h0);
        mem_block = 1'b0;
`endif
        wait_valid();
        chk("t6_pc_after", pc_actual, 32'h0);
        chk("t6_ir_after", instr_completa, 32'h0000_0020);
`ifdef BUSQ_TIMEOUT_EN
        chk("t6_err_sticky", {31'b0, error_bus}, 32'h1);
`endif
        cyc();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

    initial begin
        #100000;
        nerr++;
        $display("FAIL watchdog: run did not end by %0t, want completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/busq_instr.md
Name: busq_instr

Overview:
- Instruction-fetch unit that produces the 6-bit opcode `instru` consumed by the `control` decoder.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register and presents it with a valid flag.
- Advances PC by 4, or loads a branch target when the datapath resolves a taken branch.

Parameters:
ANCHO_DIR, 32, width of PC and memory address
PC_INICIO, 32'h0000_0000, PC value loaded at reset (low 2 bits must be 00)
LIMITE_ESPERA, 16, cycles to wait for mem_ack before timeout (used only with BUSQ_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; one clock, asynchronous, active-low
mem_req  output  1  instruction memory read request
mem_dir  output  ANCHO_DIR  word address of the read
mem_ack  input  1  memory has valid data on mem_dato this cycle
mem_dato  input  32  instruction word from memory
detener  input  1  stall from downstream; hold the current instruction
salto_tomado  input  1  taken-branch indication
dir_salto  input  ANCHO_DIR  branch target address
instr_valida  output  1  instr_completa/instru are valid
instr_completa  output  32  latched instruction register
instru  output  6  opcode field instr_completa[31:26], to control
pc_actual  output  ANCHO_DIR  address of the instruction in instr_completa
error_bus  output  1  sticky fetch timeout flag (tied 0 without the feature)

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - pc_actual=PC_INICIO, mem_dir=PC_INICIO
  - mem_req=0, instr_valida=0, instr_completa=0, instru=6'b000000, error_bus=0
  - state=INACTIVO
- All outputs are registered.
- FSM states: INACTIVO, PEDIR, ENTREGAR.
- INACTIVO:
  - mem_req=0, instr_valida=0.
  - Unconditionally goes to PEDIR on the next edge.
  - mem_ack is ignored.
- PEDIR:
  - mem_req=1, mem_dir=pc; both held stable until mem_ack.
  - On the edge where mem_ack=1 is sampled: IR<=mem_dato, mem_req<=0, go to ENTREGAR.
  - Zero-wait memory (ack in the first PEDIR cycle) is legal.
- ENTREGAR:
  - instr_valida=1; instru=IR[31:26]; pc_actual=address of IR.
  - detener=1: stay in ENTREGAR; IR, PC and outputs all held.
  - detener=0, salto_tomado=0: pc<=pc+4 (modulo 2^ANCHO_DIR; 0xFFFFFFFC wraps to 0), go to PEDIR.
  - detener=0, salto_tomado=1: pc<={dir_salto[ANCHO_DIR-1:2],2'b00}, go to PEDIR.
  - instr_valida drops on the edge leaving ENTREGAR.
  - mem_ack is ignored in this state.
- Latency:
  - Ack sampled at edge N: instr_valida=1 during cycle N..N+1.
  - Next mem_req rises at edge N+1 at the earliest.
  - Minimum 2 cycles per instruction.
- Branch boundary cases:
  - salto_tomado is ignored in INACTIVO and PEDIR.
  - salto_tomado is ignored in ENTREGAR while detener=1; the control side must hold it until detener=0.
- Reset mid-transaction: outstanding request is abandoned. A late mem_ack after reset arrives in INACTIVO and is discarded.
- mem_dir[1:0] is always 00.

Optional Feature:
- Macro: BUSQ_TIMEOUT_EN.
- Defined:
  - A counter runs in PEDIR and clears on entering PEDIR.
  - If mem_ack has not arrived after LIMITE_ESPERA cycles: error_bus<=1 (sticky until reset), mem_req<=0, go to INACTIVO.
  - The same pc is then re-requested; pc does not advance.
- Undefined:
  - No counter is instantiated; PEDIR waits indefinitely.
  - error_bus is constant 0.

Test Plan:
- Reset release, memory acks 1 cycle after req with mem_dato=32'h8C08_0004 -> mem_dir=0x0, then instru=6'b100011, instr_valida=1 for one cycle, next mem_dir=0x4.
- Sequential fetch of 0x00000020 (R-type), 0xAC08_0004, 0x1109_0003 -> instru sequence 000000, 101011, 000100, pc_actual 0x0, 0x4, 0x8.
- detener=1 for 3 cycles during ENTREGAR -> instr_valida and instru held 3+1 cycles, mem_req stays 0, pc unchanged.
- salto_tomado=1, dir_salto=0x0000_0043 with detener=0 -> next mem_dir=0x0000_0040. Same pulse while detener=1 -> ignored.
- rst_n pulsed low while mem_req=1, ack arrives 2 cycles later -> outputs return to reset values immediately, late ack discarded, first fetch after release is at PC_INICIO.
- BUSQ_TIMEOUT_EN defined, ack withheld 16 cycles -> error_bus=1, mem_req low for 1 cycle, re-issued at the same mem_dir. Without the macro -> mem_req held indefinitely, error_bus=0.
